// File: rtl/sc_level_sequencer_pkg.sv
// Shared definitions for the level sequencer: FSM state encoding,
// per-level obstacle speeds and default game dimensions.
package sc_level_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } levelState_t;

  localparam int SPEED_LVL1 = 2;
  localparam int SPEED_LVL2 = 4;
  localparam int SPEED_LVL3 = 7;

  localparam int DEFAULT_LEVEL_DATAWIDTH    = 3;
  localparam int DEFAULT_PROGRESS_DATAWIDTH = 5;
  localparam int DEFAULT_SPEED_DATAWIDTH    = 4;
  localparam int DEFAULT_GOALS_PER_LEVEL    = 12;
  localparam int DEFAULT_MAX_LEVEL          = 3;
  localparam int DEFAULT_PAUSE_TICKS        = 8;

  // Obstacle speed for a level number; "no level" and end-game run at speed 0.
  function automatic int speedForLevel(input int level);
    case (level)
      1:       return SPEED_LVL1;
      2:       return SPEED_LVL2;
      3:       return SPEED_LVL3;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/sc_level_sequencer_if.sv
// Bundle between the level sequencer and the game logic around it.
// The master side drives start/goal/tick, the slave side (sequencer)
// drives level status, speed and field-clear back.
interface sc_level_sequencer_if
  import sc_level_sequencer_pkg::*;
#(
  parameter int LEVEL_DATAWIDTH    = DEFAULT_LEVEL_DATAWIDTH,
  parameter int PROGRESS_DATAWIDTH = DEFAULT_PROGRESS_DATAWIDTH,
  parameter int SPEED_DATAWIDTH    = DEFAULT_SPEED_DATAWIDTH
);

  logic                          start;
  logic                          goalReached;
  logic                          tick;
  logic [LEVEL_DATAWIDTH-1:0]    currentLevel;
  logic [PROGRESS_DATAWIDTH-1:0] lvlProgressCount;
  logic                          pause;
  logic                          clearField;
  logic [SPEED_DATAWIDTH-1:0]    speedSel;
  logic                          finishedGame;

  modport master (
    output start, goalReached, tick,
    input  currentLevel, lvlProgressCount, pause, clearField, speedSel, finishedGame
  );

  modport slave (
    input  start, goalReached, tick,
    output currentLevel, lvlProgressCount, pause, clearField, speedSel, finishedGame
  );

endinterface

// File: rtl/sc_level_sequencer_pause_timer.sv
// Inter-level pause timer: loadable down-counter advanced by the timebase
// tick. The done strobe fires on the tick that consumes the last count.
module sc_level_sequencer_pause_timer
  import sc_level_sequencer_pkg::*;
#(
  parameter int PAUSE_TICKS = DEFAULT_PAUSE_TICKS
) (
  input  logic SC_LEVEL_SEQUENCER_CLOCK_50,
  input  logic SC_LEVEL_SEQUENCER_RESET_InHigh,
  input  logic load,
  input  logic tickEnable,
  output logic done
);

  localparam int COUNT_WIDTH = $clog2(PAUSE_TICKS + 1);

  logic [COUNT_WIDTH-1:0] pauseCount;

  // Load the full pause length, then count down one per enabled tick, stopping at zero.
  always_ff @(posedge SC_LEVEL_SEQUENCER_CLOCK_50) begin
    if (SC_LEVEL_SEQUENCER_RESET_InHigh) begin
      pauseCount <= '0;
    end else if (load) begin
      pauseCount <= COUNT_WIDTH'(PAUSE_TICKS);
    end else if (tickEnable && (pauseCount != '0)) begin
      pauseCount <= pauseCount - COUNT_WIDTH'(1);
    end
  end

  assign done = tickEnable && (pauseCount == COUNT_WIDTH'(1));

endmodule

// File: rtl/sc_level_sequencer.sv
// Level sequencer for the frog game: counts goal arrivals, advances the
// level after a timed pause and parks in DONE after the last level.
// All outputs come from registered state only.
module sc_level_sequencer
  import sc_level_sequencer_pkg::*;
#(
  parameter int LEVEL_DATAWIDTH    = DEFAULT_LEVEL_DATAWIDTH,
  parameter int PROGRESS_DATAWIDTH = DEFAULT_PROGRESS_DATAWIDTH,
  parameter int GOALS_PER_LEVEL    = DEFAULT_GOALS_PER_LEVEL,
  parameter int MAX_LEVEL          = DEFAULT_MAX_LEVEL,
  parameter int PAUSE_TICKS        = DEFAULT_PAUSE_TICKS,
  parameter int SPEED_DATAWIDTH    = DEFAULT_SPEED_DATAWIDTH
) (
  input logic                 SC_LEVEL_SEQUENCER_CLOCK_50,
  input logic                 SC_LEVEL_SEQUENCER_RESET_InHigh,
  sc_level_sequencer_if.slave bus
);

  levelState_t                   state;
  levelState_t                   stateNext;
  logic [LEVEL_DATAWIDTH-1:0]    currentLevel;
  logic [LEVEL_DATAWIDTH-1:0]    levelNext;
  logic [PROGRESS_DATAWIDTH-1:0] progressCount;
  logic [PROGRESS_DATAWIDTH-1:0] progressNext;
  logic                          clearField;
  logic                          clearFieldNext;
  logic                          goalPrev;
  logic                          goalEvent;
  logic                          timerLoad;
  logic                          timerTickEnable;
  logic                          timerDone;

  assign goalEvent       = bus.goalReached && !goalPrev;
  assign timerTickEnable = bus.tick && (state == ST_PAUSE);

  sc_level_sequencer_pause_timer #(
    .PAUSE_TICKS(PAUSE_TICKS)
  ) pauseTimer (
    .SC_LEVEL_SEQUENCER_CLOCK_50    (SC_LEVEL_SEQUENCER_CLOCK_50),
    .SC_LEVEL_SEQUENCER_RESET_InHigh(SC_LEVEL_SEQUENCER_RESET_InHigh),
    .load                           (timerLoad),
    .tickEnable                     (timerTickEnable),
    .done                           (timerDone)
  );

  // Next-state decision: start, goal counting, pause expiry and end-game.
  always_comb begin
    stateNext      = state;
    levelNext      = currentLevel;
    progressNext   = progressCount;
    clearFieldNext = 1'b0;
    timerLoad      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          stateNext      = ST_PLAY;
          levelNext      = LEVEL_DATAWIDTH'(1);
          progressNext   = '0;
          clearFieldNext = 1'b1;
        end
      end
      ST_PLAY: begin
        if (goalEvent) begin
          if (progressCount == PROGRESS_DATAWIDTH'(GOALS_PER_LEVEL - 1)) begin
            progressNext = PROGRESS_DATAWIDTH'(GOALS_PER_LEVEL);
            stateNext    = ST_PAUSE;
            timerLoad    = 1'b1;
          end else begin
            progressNext = progressCount + PROGRESS_DATAWIDTH'(1);
          end
        end
      end
      ST_PAUSE: begin
        if (timerDone) begin
          progressNext = '0;
          if (currentLevel < LEVEL_DATAWIDTH'(MAX_LEVEL)) begin
            stateNext      = ST_PLAY;
            levelNext      = currentLevel + LEVEL_DATAWIDTH'(1);
            clearFieldNext = 1'b1;
          end else begin
            stateNext = ST_DONE;
            levelNext = LEVEL_DATAWIDTH'(MAX_LEVEL + 1);
          end
        end
      end
      ST_DONE: begin
        stateNext = ST_DONE;
      end
      default: begin
        stateNext = ST_IDLE;
      end
    endcase
  end

  // State, level/progress registers and the goal edge-detect history.
  always_ff @(posedge SC_LEVEL_SEQUENCER_CLOCK_50) begin
    if (SC_LEVEL_SEQUENCER_RESET_InHigh) begin
      state         <= ST_IDLE;
      currentLevel  <= '0;
      progressCount <= '0;
      clearField    <= 1'b0;
      goalPrev      <= 1'b0;
    end else begin
      state         <= stateNext;
      currentLevel  <= levelNext;
      progressCount <= progressNext;
      clearField    <= clearFieldNext;
      goalPrev      <= bus.goalReached;
    end
  end

  assign bus.currentLevel     = currentLevel;
  assign bus.lvlProgressCount = progressCount;
  assign bus.pause            = (state == ST_PAUSE);
  assign bus.clearField       = clearField;
  assign bus.finishedGame     = (state == ST_DONE);
  assign bus.speedSel         = SPEED_DATAWIDTH'(speedForLevel(int'(currentLevel)));

endmodule

// File: tb/tb_sc_level_sequencer.sv
// Scoreboard bench for sc_level_sequencer: directed game walkthroughs
// followed by randomized play, checked against a behavioural game model.
module tb_sc_level_sequencer;

  localparam int GOALS  = 12;
  localparam int MAXLVL = 3;
  localparam int PAUSET = 8;

  typedef struct {
    int level;
    int progress;
    int pause;
    int clear;
    int speed;
    int finished;
  } expect_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  expect_t sbQ[$];
  int total = 0;
  int bad   = 0;

  // Behavioural game model
  int mLevel     = 0;
  int mGoals     = 0;
  int mTicksLeft = 0;
  bit mStarted   = 0;
  bit mInPause   = 0;
  bit mFinished  = 0;
  bit mLastGoal  = 0;
  int speedTable[8] = '{0, 2, 4, 7, 0, 0, 0, 0};

  sc_level_sequencer_if #(
    .LEVEL_DATAWIDTH   (3),
    .PROGRESS_DATAWIDTH(5),
    .SPEED_DATAWIDTH   (4)
  ) bus ();

  sc_level_sequencer #(
    .LEVEL_DATAWIDTH   (3),
    .PROGRESS_DATAWIDTH(5),
    .GOALS_PER_LEVEL   (GOALS),
    .MAX_LEVEL         (MAXLVL),
    .PAUSE_TICKS       (PAUSET),
    .SPEED_DATAWIDTH   (4)
  ) dut (
    .SC_LEVEL_SEQUENCER_CLOCK_50    (clk),
    .SC_LEVEL_SEQUENCER_RESET_InHigh(rst),
    .bus                            (bus)
  );

  always #10 clk = ~clk;

  // Advance the game model by one clock given this cycle's inputs.
  task automatic modelStep(input bit r, input bit s, input bit g, input bit t);
    expect_t e;
    bit goalEdge;
    bit clearPulse;
    goalEdge   = g && !mLastGoal;
    mLastGoal  = r ? 1'b0 : g;
    clearPulse = 0;
    if (r) begin
      mLevel = 0; mGoals = 0; mTicksLeft = 0;
      mStarted = 0; mInPause = 0; mFinished = 0;
    end else if (mFinished) begin
      // game over: only reset leaves
    end else if (!mStarted) begin
      if (s) begin
        mStarted = 1; mLevel = 1; mGoals = 0; clearPulse = 1;
      end
    end else if (mInPause) begin
      if (t) begin
        mTicksLeft = mTicksLeft - 1;
        if (mTicksLeft == 0) begin
          mInPause = 0;
          mGoals   = 0;
          if (mLevel == MAXLVL) begin
            mFinished = 1;
            mLevel    = MAXLVL + 1;
          end else begin
            mLevel     = mLevel + 1;
            clearPulse = 1;
          end
        end
      end
    end else if (goalEdge) begin
      mGoals = mGoals + 1;
      if (mGoals == GOALS) begin
        mInPause   = 1;
        mTicksLeft = PAUSET;
      end
    end
    e.level    = mLevel;
    e.progress = mGoals;
    e.pause    = mInPause ? 1 : 0;
    e.clear    = clearPulse ? 1 : 0;
    e.speed    = speedTable[mLevel];
    e.finished = mFinished ? 1 : 0;
    sbQ.push_back(e);
  endtask

  // Drive one cycle of inputs after the monitor has sampled, and queue its expected outcome.
  task automatic applyStimulus(input bit r, input bit s, input bit g, input bit t);
    @(negedge clk);
    #1;
    rst             = r;
    bus.start       = s;
    bus.goalReached = g;
    bus.tick        = t;
    modelStep(r, s, g, t);
  endtask

  task automatic goalPulse();
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0);
  endtask

  task automatic tickPulse();
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0);
  endtask

  // Compare one DUT output snapshot against the model's prediction.
  task automatic checkOutput(input expect_t e);
    total++;
    if (int'(bus.currentLevel) != e.level || int'(bus.lvlProgressCount) != e.progress ||
        int'(bus.pause) != e.pause || int'(bus.clearField) != e.clear ||
        int'(bus.speedSel) != e.speed || int'(bus.finishedGame) != e.finished) begin
      bad++;
      $display("[TB] FAIL outputs t=%0t got lvl=%0d prog=%0d pause=%0d clr=%0d spd=%0d fin=%0d want lvl=%0d prog=%0d pause=%0d clr=%0d spd=%0d fin=%0d",
               $time, bus.currentLevel, bus.lvlProgressCount, bus.pause, bus.clearField,
               bus.speedSel, bus.finishedGame, e.level, e.progress, e.pause, e.clear,
               e.speed, e.finished);
    end
  endtask

  // Monitor: each clock the DUT presents a snapshot; pop and compare when one is owed.
  always @(negedge clk) begin : monitor
    expect_t e;
    if (sbQ.size() != 0) begin
      e = sbQ.pop_front();
      checkOutput(e);
    end
  end

  initial begin
    bus.start       = 1'b0;
    bus.goalReached = 1'b0;
    bus.tick        = 1'b0;

    repeat (3) applyStimulus(1, 0, 0, 0);

    // Goals in IDLE are ignored; start with a simultaneous rising goal counts start only.
    goalPulse();
    applyStimulus(0, 1, 1, 0);
    repeat (20) applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1);
    repeat (20) applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0);
    repeat (11) goalPulse();

    // In PAUSE: goals ignored, goal+tick decrements only, 7 ticks stay paused.
    repeat (2) goalPulse();
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0);
    repeat (6) tickPulse();
    repeat (3) applyStimulus(0, 0, 0, 0);
    tickPulse();

    // Level 2, then reset in the middle of its pause.
    repeat (12) goalPulse();
    repeat (3) tickPulse();
    applyStimulus(1, 0, 0, 0);
    repeat (2) applyStimulus(0, 0, 0, 0);

    // Full game to end-game, then start and goals have no effect.
    applyStimulus(0, 1, 0, 0);
    for (int lvl = 1; lvl <= MAXLVL; lvl++) begin
      repeat (GOALS) goalPulse();
      repeat (PAUSET) tickPulse();
    end
    repeat (3) applyStimulus(0, 1, 0, 0);
    repeat (3) goalPulse();

    // Randomized play with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 299) == 0),
                    ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 1) == 1),
                    ($urandom_range(0, 2) == 0));
    end
    applyStimulus(0, 0, 0, 0);

    for (int i = 0; i < 5 && sbQ.size() != 0; i++) @(negedge clk);
    #2;
    if (sbQ.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain pending=%0d want 0", sbQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
